// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the data-memory arbiter.
package dmem_arb_pkg;

    // Transaction sequencer states.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    // Requester identifiers; also the index into the per-port vectors.
    localparam logic PORT_C = 1'b0;
    localparam logic PORT_A = 1'b1;

    // Width of the access-latency counter (covers MEM_LAT up to 7).
    localparam int CNT_W = 3;

    // Word alignment test on the two low address bits.
    function automatic logic is_aligned(input logic [1:0] lsb);
        return (lsb == 2'b00);
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-requester picker: round-robin when rr_en is set, otherwise C wins ties.
// gnt is only meaningful when at least one request is present.
module rr_arb2
    import dmem_arb_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last_gnt,
    input  logic       rr_en,
    output logic       gnt
);

    // Choose the winner among the active requests.
    always_comb begin
        gnt = PORT_C;
        if (req[PORT_C] && req[PORT_A]) begin
            gnt = rr_en ? ~last_gnt : PORT_C;
        end else if (req[PORT_A]) begin
            gnt = PORT_A;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares the single-port data memory between the CPU (port C) and the
// auxiliary loader/debug port (port A). Each access runs as a fixed-latency
// transaction IDLE -> ACCESS -> DONE; misaligned requests skip ACCESS.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 32,
    parameter int MEM_LAT = 1,
    parameter bit RR_EN   = 1'b1
) (
    input  logic              clk_i,
    input  logic              rst_i,

    input  logic              C_REQ_i,
    input  logic              C_WE_i,
    input  logic [ADDR_W-1:0] C_ADDR_i,
    input  logic [DATA_W-1:0] C_WDATA_i,
    output logic              C_DONE_o,
    output logic              C_ERR_o,
    output logic [DATA_W-1:0] C_RDATA_o,
    output logic              C_STALL_o,

    input  logic              A_REQ_i,
    input  logic              A_WE_i,
    input  logic [ADDR_W-1:0] A_ADDR_i,
    input  logic [DATA_W-1:0] A_WDATA_i,
    output logic              A_DONE_o,
    output logic              A_ERR_o,
    output logic [DATA_W-1:0] A_RDATA_o,

    output logic              MEM_EN_o,
    output logic              MEM_WE_o,
    output logic [ADDR_W-1:0] MEM_ADDR_o,
    output logic [DATA_W-1:0] MEM_WDATA_o,
    input  logic [DATA_W-1:0] MEM_RDATA_i
);

    // Last counter value of the ACCESS phase; the read data is sampled then.
    localparam logic [CNT_W-1:0] LAT_CNT = CNT_W'(MEM_LAT);

    // Registered state and its next-state values.
    state_t            state_reg, state_next;
    logic [CNT_W-1:0]  cnt_reg, cnt_next;
    logic              gnt_reg, gnt_next;
    logic              last_gnt_reg, last_gnt_next;
    logic              err_reg, err_next;
    logic              we_reg, we_next;
    logic [ADDR_W-1:0] addr_reg, addr_next;
    logic [DATA_W-1:0] wdata_reg, wdata_next;
    logic [DATA_W-1:0] rdata_reg, rdata_next;

    // Per-port views of the requester interfaces, indexed by port id.
    logic [1:0]        req_vec;
    logic [1:0]        we_vec;
    logic [ADDR_W-1:0] addr_vec  [2];
    logic [DATA_W-1:0] wdata_vec [2];
    logic [1:0]        port_done;
    logic [1:0]        port_err;
    logic              pick;
    logic              in_access;
    logic              in_done;

    assign req_vec      = {A_REQ_i, C_REQ_i};
    assign we_vec       = {A_WE_i, C_WE_i};
    assign addr_vec[0]  = C_ADDR_i;
    assign addr_vec[1]  = A_ADDR_i;
    assign wdata_vec[0] = C_WDATA_i;
    assign wdata_vec[1] = A_WDATA_i;

    assign in_access = (state_reg == ACCESS);
    assign in_done   = (state_reg == DONE);

    rr_arb2 u_rr_arb2 (
        .req      (req_vec),
        .last_gnt (last_gnt_reg),
        .rr_en    (RR_EN),
        .gnt      (pick)
    );

    // Completion and error pulses go only to the granted port.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_port
            assign port_done[gi] = in_done && (gnt_reg == (gi == 1));
            assign port_err[gi]  = port_done[gi] && err_reg;
        end
    endgenerate

    assign C_DONE_o  = port_done[PORT_C];
    assign A_DONE_o  = port_done[PORT_A];
    assign C_ERR_o   = port_err[PORT_C];
    assign A_ERR_o   = port_err[PORT_A];
    assign C_RDATA_o = rdata_reg;
    assign A_RDATA_o = rdata_reg;
    assign C_STALL_o = C_REQ_i & ~C_DONE_o;

    // Memory command is held from the latched registers for the whole
    // ACCESS phase; the strobe fires only in its first cycle.
    assign MEM_EN_o    = in_access && (cnt_reg == '0);
    assign MEM_WE_o    = in_access && we_reg;
    assign MEM_ADDR_o  = in_access ? addr_reg  : '0;
    assign MEM_WDATA_o = in_access ? wdata_reg : '0;

    // Sequencer next-state logic: arbitrate in IDLE, count latency in ACCESS,
    // retire in DONE.
    always_comb begin
        state_next    = state_reg;
        cnt_next      = cnt_reg;
        gnt_next      = gnt_reg;
        last_gnt_next = last_gnt_reg;
        err_next      = err_reg;
        we_next       = we_reg;
        addr_next     = addr_reg;
        wdata_next    = wdata_reg;
        rdata_next    = rdata_reg;

        case (state_reg)
            IDLE: begin
                if (|req_vec) begin
                    gnt_next   = pick;
                    we_next    = we_vec[pick];
                    addr_next  = addr_vec[pick];
                    wdata_next = wdata_vec[pick];
                    cnt_next   = '0;
                    if (is_aligned(addr_vec[pick][1:0])) begin
                        err_next   = 1'b0;
                        state_next = ACCESS;
                    end else begin
                        // Misaligned: report immediately, never touch memory.
                        err_next   = 1'b1;
                        state_next = DONE;
                    end
                end
            end
            ACCESS: begin
                if (cnt_reg == LAT_CNT) begin
                    if (!we_reg) begin
                        rdata_next = MEM_RDATA_i;
                    end
                    state_next = DONE;
                end else begin
                    cnt_next = cnt_reg + CNT_W'(1);
                end
            end
            DONE: begin
                // Requests are not sampled here so the finished one is not
                // granted twice.
                last_gnt_next = gnt_reg;
                state_next    = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset abandons any open transaction.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_reg    <= IDLE;
            cnt_reg      <= '0;
            gnt_reg      <= PORT_C;
            last_gnt_reg <= PORT_A;
            err_reg      <= 1'b0;
            we_reg       <= 1'b0;
            addr_reg     <= '0;
            wdata_reg    <= '0;
            rdata_reg    <= '0;
        end else begin
            state_reg    <= state_next;
            cnt_reg      <= cnt_next;
            gnt_reg      <= gnt_next;
            last_gnt_reg <= last_gnt_next;
            err_reg      <= err_next;
            we_reg       <= we_next;
            addr_reg     <= addr_next;
            wdata_reg    <= wdata_next;
            rdata_reg    <= rdata_next;
        end
    end

endmodule
